// File: rtl/uart_stream_arbiter.sv
// uart_stream_arbiter: packet-granular arbiter sharing one UART TX byte stream between NUM_REQ requesters.
// Define UART_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest) instead of round-robin.
module uart_stream_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_REQ-1:0] in_data,
    input  logic [NUM_REQ-1:0]   in_valid,
    input  logic [NUM_REQ-1:0]   in_last,
    output logic [NUM_REQ-1:0]   in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 stall_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(STALL_TIMEOUT);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state, state_n;
    logic [IW-1:0] own, win;
    logic [CW-1:0] cnt;
    logic [7:0]    own_data;
    logic          own_valid, own_last, any_req, done, tout;
`ifndef UART_ARB_FIXED_PRIORITY_EN
    logic [IW-1:0] rr_ptr;
`endif

    always_comb begin
        any_req = |in_valid;
        win     = '0;
`ifdef UART_ARB_FIXED_PRIORITY_EN
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (in_valid[i]) win = IW'(i);
`else
        // descending scan so the candidate closest to rr_ptr is assigned last and wins
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (in_valid[(int'(rr_ptr) + i) % NUM_REQ]) win = IW'((int'(rr_ptr) + i) % NUM_REQ);
`endif
    end

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (own == IW'(i)) begin
                own_valid = in_valid[i];
                own_last  = in_last[i];
                own_data  = in_data[8*i +: 8];
            end
    end

    always_comb begin
        out_valid = (state == OWNED) && own_valid;
        out_data  = (state == OWNED) ? own_data : 8'h00;
        in_ready  = (state == OWNED && out_ready) ? grant : '0;
        done      = out_valid && out_ready && own_last;
        tout      = (state == OWNED) && !own_valid && (cnt == CW'(STALL_TIMEOUT - 1));
        state_n   = state;
        if (state == IDLE) state_n = any_req ? OWNED : IDLE;
        else state_n = (done || tout) ? IDLE : OWNED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            own       <= '0;
            cnt       <= '0;
            stall_err <= 1'b0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
            rr_ptr    <= '0;
`endif
        end else begin
            state     <= state_n;
            stall_err <= tout && !done;
            if (state == IDLE && any_req) begin
                own   <= win;
                grant <= NUM_REQ'(1) << win;
                cnt   <= '0;
`ifndef UART_ARB_FIXED_PRIORITY_EN
                rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
            end else if (state == OWNED && (done || tout)) begin
                grant <= '0;
                cnt   <= '0;
            end else if (state == OWNED) begin
                cnt <= own_valid ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_stream_arbiter.sv
// tb_uart_stream_arbiter: directed scoreboard bench for uart_stream_arbiter (NUM_REQ=2, STALL_TIMEOUT=16).
module tb_uart_stream_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [1:0]  in_valid, in_last, in_ready, grant, hold;
    logic [7:0]  out_data;
    logic        out_valid, out_ready, stall_err;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic [8:0] src[2][$];
    logic [1:0] gseq[$];
    logic [1:0] gexp[4];
    logic [1:0] prev;
    int bad;

    uart_stream_arbiter #(.NUM_REQ(2), .STALL_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .grant(grant), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            in_valid[i]       = !hold[i] && src[i].size() > 0;
            in_data[i*8 +: 8] = src[i].size() > 0 ? src[i][0][7:0] : 8'h00;
            in_last[i]        = src[i].size() > 0 && src[i][0][8];
        end
    endtask

    // samples the handshake about to happen, crosses one edge, then retires accepted bytes
    task automatic tick();
        logic [1:0] acc;
        acc = rst ? 2'b00 : (in_valid & in_ready);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_byte", 32'(out_valid), 32'd0);
            else chk("out_byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
        drive();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) tick();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; hold = 2'b00;
        drive();
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_stall_err", 32'(stall_err), 32'd0);

        // requester 1 sends 41 42 43
        src[1] = '{9'h041, 9'h042, 9'h143};
        exp_q = '{8'h41, 8'h42, 8'h43};
        drive();
        tick();
        chk("p1_grant", 32'(grant), 32'd2);
        chk("p1_first_data", 32'(out_data), 32'h41);
        tick(); tick(); tick();
        chk("p1_drained", 32'(exp_q.size()), 32'd0);
        chk("p1_grant_idle", 32'(grant), 32'd0);
        chk("p1_out_valid_idle", 32'(out_valid), 32'd0);

        // both requesters with two 2-byte packets each
        src[0] = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3};
        src[1] = '{9'h0B0, 9'h1B1, 9'h0B2, 9'h1B3};
`ifdef UART_ARB_FIXED_PRIORITY_EN
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        gexp = '{2'b01, 2'b01, 2'b10, 2'b10};
`else
        exp_q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
        gexp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        drive();
        prev = 2'b00;
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
            tick();
            if (grant != 2'b00 && prev == 2'b00) gseq.push_back(grant);
            prev = grant;
        end
        chk("p2_drained", 32'(exp_q.size()), 32'd0);
        chk("p2_grant_count", 32'(gseq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gseq.size(); i++) chk("p2_grant_order", 32'(gseq[i]), 32'(gexp[i]));

        // requester 1 arrives while requester 0 is mid-packet
        src[0] = '{9'h0C0, 9'h0C1, 9'h1C2};
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hD0};
        drive();
        tick();
        chk("p3_grant", 32'(grant), 32'd1);
        chk("p3_owner_ready", 32'(in_ready[0]), 32'd1);
        src[1] = '{9'h1D0};
        drive();
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
            if (grant == 2'b01) chk("p3_nonowner_ready", 32'(in_ready[1]), 32'd0);
            tick();
        end
        chk("p3_drained", 32'(exp_q.size()), 32'd0);

        // owner stalls after one byte; requester 1 waits
        src[0] = '{9'h0E0, 9'h1E1};
        src[1] = '{9'h1F0};
        exp_q = '{8'hE0, 8'hF0};
        drive();
        tick();
        chk("p4_grant", 32'(grant), 32'd1);
        hold[0] = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("p4_stall_err", 32'(stall_err), 32'(k == 16));
            if (k == 16) chk("p4_grant_released", 32'(grant), 32'd0);
            if (k == 17) chk("p4_waiter_granted", 32'(grant), 32'd2);
        end
        chk("p4_drained", 32'(exp_q.size()), 32'd0);
        src[0].delete();
        hold[0] = 1'b0;
        drive();

        // long backpressure is not a stall
        src[0] = '{9'h155};
        exp_q = '{8'h55};
        out_ready = 1'b0;
        drive();
        tick();
        bad = 0;
        for (int n = 0; n < 5000; n++) begin
            if (stall_err || !out_valid || out_data != 8'h55 || grant != 2'b01) bad++;
            tick();
        end
        chk("p5_backpressure_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("p5_drained", 32'(exp_q.size()), 32'd0);
        chk("p5_grant_idle", 32'(grant), 32'd0);

        // reset during byte 2 of a 4-byte packet
        src[0] = '{9'h060, 9'h061, 9'h062, 9'h163};
        exp_q = '{8'h60};
        drive();
        tick(); tick();
        chk("p6_byte2_shown", 32'(out_data), 32'h61);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("p6_rst_grant", 32'(grant), 32'd0);
        chk("p6_rst_in_ready", 32'(in_ready), 32'd0);
        chk("p6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("p6_rst_out_data", 32'(out_data), 32'd0);
        chk("p6_rst_stall_err", 32'(stall_err), 32'd0);
        chk("p6_drained_before", 32'(exp_q.size()), 32'd0);
        src[0] = '{9'h170};
        src[1] = '{9'h171};
        exp_q = '{8'h70, 8'h71};
        drive();
        tick();
        chk("p6_fresh_grant", 32'(grant), 32'd1);
        drain("p6_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
